// File: rtl/decoder_bank.sv
// Purpose: bank of three registered one-hot decoders (1x2 w/ enable, 2x4 w/ enable, 3x8 always on).
// Latency: one clock from input sample edge to output; async active-low reset clears all outputs.
// Backpressure: none; every decoder re-samples its inputs on every rising edge.
module decoder_bank (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d1_a,
  input  logic       d1_en,
  output logic [1:0] d1_y,
  input  logic       d2_a,
  input  logic       d2_b,
  input  logic       d2_en,
  output logic [3:0] d2_y,
  input  logic       d3_a,
  input  logic       d3_b,
  input  logic       d3_c,
  output logic [7:0] d3_y
);

  logic [1:0] d2_idx;
  logic [2:0] d3_idx;

  assign d2_idx = {d2_a, d2_b};
  assign d3_idx = {d3_a, d3_b, d3_c};

  // 1x2 decode: one select line when enabled, all-zero otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_y <= 2'b00;
    end else if (d1_en) begin
      d1_y <= 2'b01 << d1_a;
    end else begin
      d1_y <= 2'b00;
    end
  end

  // 2x4 decode: a is the MSB of the index; disabled means all-zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d2_y <= 4'b0000;
    end else if (d2_en) begin
      d2_y <= 4'b0001 << d2_idx;
    end else begin
      d2_y <= 4'b0000;
    end
  end

  // 3x8 decode: always enabled, so zero is only seen while reset is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d3_y <= 8'h00;
    end else begin
      d3_y <= 8'h01 << d3_idx;
    end
  end

endmodule

// File: tb/tb_decoder_bank.sv
module tb_decoder_bank;

  logic       clk;
  logic       rst_n;
  logic       d1_a;
  logic       d1_en;
  logic [1:0] d1_y;
  logic       d2_a;
  logic       d2_b;
  logic       d2_en;
  logic [3:0] d2_y;
  logic       d3_a;
  logic       d3_b;
  logic       d3_c;
  logic [7:0] d3_y;

  int total;
  int bad;

  decoder_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d1_a  (d1_a),
    .d1_en (d1_en),
    .d1_y  (d1_y),
    .d2_a  (d2_a),
    .d2_b  (d2_b),
    .d2_en (d2_en),
    .d2_y  (d2_y),
    .d3_a  (d3_a),
    .d3_b  (d3_b),
    .d3_c  (d3_c),
    .d3_y  (d3_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to one step past the next rising edge; outputs are stable there
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_d1 [4];
  logic [3:0] exp_d2 [4];
  logic [7:0] exp_d3 [8];
  logic [1:0] e1;
  logic [3:0] e2;
  logic [7:0] e3;
  logic       p1, p2, p3;

  initial begin
    exp_d1 = '{2'b00, 2'b00, 2'b01, 2'b10};
    exp_d2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_d3 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    total = 0;
    bad   = 0;

    // reset held with arbitrary non-zero inputs, checked before any edge
    rst_n = 1'b0;
    d1_a = 1'b1; d1_en = 1'b1;
    d2_a = 1'b1; d2_b = 1'b0; d2_en = 1'b1;
    d3_a = 1'b1; d3_b = 1'b1; d3_c = 1'b0;
    #2;
    chk("rst_d1", {6'b0, d1_y}, 8'h00);
    chk("rst_d2", {4'b0, d2_y}, 8'h00);
    chk("rst_d3", d3_y, 8'h00);
    tick();
    tick();
    chk("rst_hold_d3", d3_y, 8'h00);

    // first edge after release loads the current inputs
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_d1", {6'b0, d1_y}, 8'h02);
    chk("rel_d2", {4'b0, d2_y}, 8'h04);
    chk("rel_d3", d3_y, 8'h40);

    // 1x2 sweep over {en,a}
    for (int i = 0; i < 4; i++) begin
      {d1_en, d1_a} = i[1:0];
      tick();
      chk($sformatf("d1_sweep%0d", i), {6'b0, d1_y}, {6'b0, exp_d1[i]});
    end

    // 2x4 sweep enabled, then disabled
    d2_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {d2_a, d2_b} = i[1:0];
      tick();
      chk($sformatf("d2_en_sweep%0d", i), {4'b0, d2_y}, {4'b0, exp_d2[i]});
    end
    d2_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {d2_a, d2_b} = i[1:0];
      tick();
      chk($sformatf("d2_dis_sweep%0d", i), {4'b0, d2_y}, 8'h00);
    end

    // 3x8 sweep
    for (int i = 0; i < 8; i++) begin
      {d3_a, d3_b, d3_c} = i[2:0];
      tick();
      chk($sformatf("d3_sweep%0d", i), d3_y, exp_d3[i]);
      chk($sformatf("d3_onehot%0d", i), {7'b0, $onehot(d3_y)}, 8'h01);
    end

    // independence: d1_a toggles every cycle, d2_b every 2, d3_c every 3
    d1_en = 1'b1; d2_en = 1'b1;
    d2_a = 1'b0; d3_a = 1'b1; d3_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      p1 = i[0];
      p2 = ((i / 2) % 2) == 1;
      p3 = ((i / 3) % 2) == 1;
      d1_a = p1; d2_b = p2; d3_c = p3;
      e1 = p1 ? 2'b10 : 2'b01;
      e2 = p2 ? 4'b0010 : 4'b0001;
      e3 = p3 ? 8'h20 : 8'h10;
      tick();
      chk($sformatf("ind_d1_%0d", i), {6'b0, d1_y}, {6'b0, e1});
      chk($sformatf("ind_d2_%0d", i), {4'b0, d2_y}, {4'b0, e2});
      chk($sformatf("ind_d3_%0d", i), d3_y, e3);
      chk($sformatf("ind_oh_%0d", i),
          {5'b0, $onehot(d1_y), $onehot(d2_y), $onehot(d3_y)}, 8'h07);
    end

    // enable falls together with a select change
    d2_en = 1'b1; d2_a = 1'b0; d2_b = 1'b1;
    tick();
    chk("simul_before", {4'b0, d2_y}, 8'h02);
    d2_en = 1'b0; d2_a = 1'b1; d2_b = 1'b0;
    tick();
    chk("simul_after", {4'b0, d2_y}, 8'h00);

    // mid-operation reset clears outputs without a clock
    d1_en = 1'b1; d1_a = 1'b0; d2_en = 1'b1;
    tick();
    chk("pre_mid_d2", {4'b0, d2_y}, 8'h04);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_d1", {6'b0, d1_y}, 8'h00);
    chk("mid_rst_d2", {4'b0, d2_y}, 8'h00);
    chk("mid_rst_d3", d3_y, 8'h00);

    // release: decoding resumes from the inputs present at the next edge
    @(negedge clk);
    rst_n = 1'b1;
    d1_a = 1'b1;
    d2_a = 1'b1; d2_b = 1'b1;
    d3_a = 1'b0; d3_b = 1'b1; d3_c = 1'b1;
    tick();
    chk("resume_d1", {6'b0, d1_y}, 8'h02);
    chk("resume_d2", {4'b0, d2_y}, 8'h08);
    chk("resume_d3", d3_y, 8'h08);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_bank.md
# decoder_bank

Registered bank of three independent binary-to-one-hot decoders: 1-to-2 with enable, 2-to-4 with enable, and 3-to-8 without enable. Every output is registered, giving a single-cycle latency behind one clock and one asynchronous active-low reset. The block serves as the shared select/strobe generator: downstream logic uses its one-hot lines to pick registers, mux legs or chip selects.

## Interface
Parameters:
- None. Widths are fixed at 1/2/3 input bits and 2/4/8 output bits.

Ports (clock and reset first):
- clk  input  1  Single clock; all state updates on the rising edge.
- rst_n  input  1  Asynchronous, active-low reset.
- d1_a  input  1  Select bit of the 1x2 decoder.
- d1_en  input  1  Active-high enable of the 1x2 decoder.
- d1_y  output  2  One-hot result; bit i corresponds to y_i.
- d2_a  input  1  MSB of the 2x4 select.
- d2_b  input  1  LSB of the 2x4 select.
- d2_en  input  1  Active-high enable of the 2x4 decoder.
- d2_y  output  4  One-hot result; bit i corresponds to y_i.
- d3_a  input  1  MSB of the 3x8 select.
- d3_b  input  1  Middle bit of the 3x8 select.
- d3_c  input  1  LSB of the 3x8 select.
- d3_y  output  8  One-hot result; bit i corresponds to y_i. This decoder has no enable.

## Operation
- 1x2 decoder:
  - d1_en=1: the next value of d1_y has bit {d1_a} set and the other bit clear.
  - d1_en=0: the next value of d1_y is 2'b00.
- 2x4 decoder:
  - Index is {d2_a,d2_b}, with a as MSB.
  - d2_en=1: the next value of d2_y is 4'b0001 << index.
  - d2_en=0: the next value of d2_y is 4'b0000.
- 3x8 decoder:
  - Index is {d3_a,d3_b,d3_c}, with a as MSB and c as LSB.
  - The next value of d3_y is 8'b1 << index. It is always enabled.
- Output invariants:
  - d3_y is one-hot at all times after reset.
  - d1_y and d2_y are one-hot or all-zero at all times.
  - Two or more bits set within one output bus is illegal.
- The three decoders are fully independent. No input of one decoder affects another decoder's output.
- Outputs are active-high.
- No state exists other than the 14 output flops.

## Timing
- Latency: exactly 1 clock. Inputs sampled at rising edge N appear on the outputs after edge N and hold until edge N+1.
- No combinational path runs from any input to any output.
- Reset:
  - Asserting rst_n=0 immediately forces d1_y=2'b00, d2_y=4'b0000 and d3_y=8'b0000_0000, without waiting for a clock.
  - d3_y=0 is the only legal non-one-hot state, and it exists only during reset.
- Reset release:
  - The first rising edge with rst_n=1 loads the decoded values of the inputs present at that edge.
  - Reset deassertion is synchronised by the integrator.
- Reset mid-operation: outputs clear asynchronously and the decoded inputs are discarded. After release, decoding resumes from current inputs; nothing is replayed.
- Enable and select changing in the same cycle: the values at the sampling edge govern. An enable falling together with a select change yields all-zero on the next cycle.
- Inputs may toggle every cycle; each cycle's output reflects the previous edge's inputs only. Consecutive one-hot values have no glitch or overlap cycle.

## Test plan
- Reset: hold rst_n=0 with arbitrary inputs, then drop rst_n mid-cycle after run. Required: d1_y=0, d2_y=0 and d3_y=0 immediately, before any clock edge.
- 1x2 sweep: step {d1_en,d1_a} through 00,01,10,11 on successive edges. Required one cycle later: d1_y = 00, 00, 01, 10.
- 2x4 sweep:
  - With d2_en=1, step {d2_a,d2_b} through 00..11. Required: d2_y = 0001, 0010, 0100, 1000.
  - Repeat with d2_en=0. Required: d2_y = 0000 throughout.
- 3x8 sweep: step {d3_a,d3_b,d3_c} through 000..111. Required: d3_y = 8'h01, 02, 04, 08, 10, 20, 40, 80, each one cycle after the input.
- Independence and latency:
  - Drive d1_a, d2_b and d3_c toggling every cycle with different phases, both enables=1. Check every cycle that each output equals the decode of its own inputs from the previous edge.
  - Check that every output is one-hot, or zero for the enable-off cases.
- Simultaneous change: on one edge drop d2_en and move {d2_a,d2_b} from 01 to 10. Required: d2_y goes from 0010 to 0000, never 0100.
